// File: rtl/hex_disp_pkg.sv
// rtl/hex_disp_pkg.sv - shared constants and FSM state type for the hex display scheduler
package hex_disp_pkg;

    localparam logic [6:0] SEG_BLANK      = 7'h7F;
    localparam int         DEF_NUM_DIGITS = 6;
    localparam int         DEF_BLINK_DIV  = 25_000_000;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_e;

endpackage

// File: rtl/hex_decoder.sv
// rtl/hex_decoder.sv - hex nibble to active-low seven-segment pattern, bit 7 is the decimal point (kept dark)
module hex_decoder (
    input  logic [3:0] hex_digit,
    output logic [7:0] segments
);

    logic [6:0] seg;

    always_comb begin
        seg = 7'h7F;
        case (hex_digit)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end

    assign segments = {1'b1, seg};

endmodule

// File: rtl/hex_display_scheduler.sv
// rtl/hex_display_scheduler.sv - time-shares one hex_decoder across NUM_DIGITS registered seven-segment outputs
module hex_display_scheduler
    import hex_disp_pkg::*;
#(
    parameter int NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int BLINK_DIV  = DEF_BLINK_DIV
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [2:0]              wr_digit,
    input  logic [3:0]              wr_value,
    input  logic                    wr_blank,
    input  logic                    wr_blink,
    output logic [7*NUM_DIGITS-1:0] hex_out,
    output logic                    busy
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(BLINK_DIV);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

    scan_state_e                    state_q, state_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic                           phase_q, phase_d;
    logic                           scan_req_q, scan_req_d;
    logic [NUM_DIGITS-1:0][3:0]     value_q, value_d;
    logic [NUM_DIGITS-1:0]          blank_q, blank_d;
    logic [NUM_DIGITS-1:0]          blink_q, blink_d;
    logic [7*NUM_DIGITS-1:0]        hex_q, hex_d;

    logic       wrap;
    logic [3:0] dec_in;
    logic [7:0] dec_seg;
    logic       unused_dp;

    assign wrap      = (cnt_q == CNT_LAST);
    assign unused_dp = dec_seg[7];

    always_comb begin
        dec_in = 4'h0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                dec_in = value_q[k];
            end
        end
    end

    hex_decoder u_dec (
        .hex_digit (dec_in),
        .segments  (dec_seg)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = wrap ? '0 : cnt_q + 1'b1;
        phase_d    = phase_q ^ wrap;
        scan_req_d = scan_req_q | wrap;
        value_d    = value_q;
        blank_d    = blank_q;
        blink_d    = blink_q;
        hex_d      = hex_q;

        case (state_q)
            IDLE: begin
                // Out-of-range digits match no index below but still trigger a scan.
                if (wr_valid) begin
                    for (int k = 0; k < NUM_DIGITS; k++) begin
                        if (wr_digit == 3'(k)) begin
                            value_d[k] = wr_value;
                            blank_d[k] = wr_blank;
                            blink_d[k] = wr_blink;
                        end
                    end
                end
                if (scan_req_q || wrap || wr_valid) begin
                    state_d    = SCAN;
                    idx_d      = '0;
                    scan_req_d = 1'b0;
                end
            end
            SCAN: begin
                for (int k = 0; k < NUM_DIGITS; k++) begin
                    if (idx_q == IDX_W'(k)) begin
                        hex_d[7*k +: 7] = (blank_q[k] || (blink_q[k] && phase_q)) ?
                                          SEG_BLANK : dec_seg[6:0];
                    end
                end
                if (idx_q == IDX_LAST) begin
                    // A wrap landing on the final digit folds into the restart.
                    idx_d      = '0;
                    scan_req_d = 1'b0;
                    if (!(scan_req_q || wrap)) begin
                        state_d = IDLE;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                idx_d      = '0;
                scan_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            phase_q    <= 1'b0;
            scan_req_q <= 1'b0;
            value_q    <= '0;
            blank_q    <= '1;
            blink_q    <= '0;
            hex_q      <= '1;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            scan_req_q <= scan_req_d;
            value_q    <= value_d;
            blank_q    <= blank_d;
            blink_q    <= blink_d;
            hex_q      <= hex_d;
        end
    end

    assign wr_ready = (state_q == IDLE);
    assign busy     = (state_q == SCAN);
    assign hex_out  = hex_q;

endmodule

// File: tb/tb_hex_display_scheduler.sv
// tb/tb_hex_display_scheduler.sv - scoreboard bench for hex_display_scheduler
module tb_hex_display_scheduler;

    localparam int N  = 6;
    localparam int D  = 64;
    localparam int DB = 4;
    localparam logic [41:0] ALL_DARK = {42{1'b1}};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_valid, wr_ready, wr_blank, wr_blink, busy;
    logic [2:0]  wr_digit;
    logic [3:0]  wr_value;
    logic [41:0] hex_out;

    logic        wr_valid_b, wr_ready_b, wr_blank_b, wr_blink_b, busy_b;
    logic [2:0]  wr_digit_b;
    logic [3:0]  wr_value_b;
    logic [6:0]  hex_out_b;

    int tests = 0;
    int fails = 0;
    int acc_cnt = 0;
    int wr_count = 0;
    int cnt_m, cnt_bm;
    logic ph_bm;
    logic busy_prev = 1'b0;
    logic [41:0] img_m = ALL_DARK;
    logic [41:0] mon_e;
    logic [41:0] exp_q[$];

    always #5 clk = ~clk;

    hex_display_scheduler #(.NUM_DIGITS(N), .BLINK_DIV(D)) dut (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_digit(wr_digit), .wr_value(wr_value), .wr_blank(wr_blank),
        .wr_blink(wr_blink), .hex_out(hex_out), .busy(busy)
    );

    hex_display_scheduler #(.NUM_DIGITS(1), .BLINK_DIV(DB)) dut_b (
        .clk(clk), .reset(reset), .wr_valid(wr_valid_b), .wr_ready(wr_ready_b),
        .wr_digit(wr_digit_b), .wr_value(wr_value_b), .wr_blank(wr_blank_b),
        .wr_blink(wr_blink_b), .hex_out(hex_out_b), .busy(busy_b)
    );

    function automatic logic [6:0] seg(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_m  <= 0;
            cnt_bm <= 0;
            ph_bm  <= 1'b0;
        end else begin
            cnt_m  <= (cnt_m == D - 1) ? 0 : cnt_m + 1;
            cnt_bm <= (cnt_bm == DB - 1) ? 0 : cnt_bm + 1;
            if (cnt_bm == DB - 1) ph_bm <= ~ph_bm;
        end
    end

    always @(posedge clk) begin
        if (!reset && wr_valid && wr_ready) acc_cnt <= acc_cnt + 1;
    end

    // End of each scan burst: compare the whole display against the oldest pending image.
    always @(negedge clk) begin
        if (reset) begin
            busy_prev <= 1'b0;
        end else begin
            if (busy_prev && !busy && exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("scan_image", hex_out, mon_e);
            end
            busy_prev <= busy;
        end
    end

    task automatic align(input int target);
        int n = 0;
        while (!(cnt_m == target && !busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) timeout("align");
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) timeout("wait_idle");
    endtask

    task automatic do_write(input logic [2:0] d, input logic [3:0] v, input logic bl,
                            input logic bk, output int waited);
        wr_valid = 1'b1;
        wr_digit = d;
        wr_value = v;
        wr_blank = bl;
        wr_blink = bk;
        waited = 0;
        while (!wr_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (!wr_ready) begin
            timeout("write_accept");
            wr_valid = 1'b0;
        end else begin
            if (int'(d) < N) img_m[7*int'(d) +: 7] = bl ? 7'h7F : seg(v);
            exp_q.push_back(img_m);
            wr_count++;
            @(posedge clk);
            @(negedge clk);
            wr_valid = 1'b0;
        end
    endtask

    initial begin
        int w;
        int n;
        logic [6:0] exp_b;
        wr_valid = 0; wr_digit = 0; wr_value = 0; wr_blank = 0; wr_blink = 0;
        wr_valid_b = 0; wr_digit_b = 0; wr_value_b = 0; wr_blank_b = 0; wr_blink_b = 0;

        repeat (3) @(negedge clk);
        check("reset_hex", hex_out, ALL_DARK);
        check("reset_ready", wr_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_hex_b", hex_out_b, 7'h7F);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_hex", hex_out, ALL_DARK);
        check("post_reset_ready", wr_ready, 1);

        // Single write: digit 2 <- 8, latency of the scan and of digit 2.
        align(8);
        do_write(3'd2, 4'h8, 1'b0, 1'b0, w);
        for (int k = 1; k <= 6; k++) begin
            check("single_busy", busy, 1);
            if (k == 3) check("single_d2_before", hex_out[20:14], 7'h7F);
            if (k == 4) check("single_d2_after", hex_out[20:14], 7'h00);
            @(negedge clk);
        end
        check("single_busy_end", busy, 0);
        check("single_ready_end", wr_ready, 1);

        // Back-pressure: second write held through the first scan.
        align(8);
        do_write(3'd3, 4'h5, 1'b0, 1'b0, w);
        do_write(3'd0, 4'h1, 1'b0, 1'b0, w);
        check("bp_wait_cycles", w, 6);
        wait_idle();

        // Out-of-range digit: accepted, one scan, display unchanged.
        align(8);
        do_write(3'd7, 4'h3, 1'b0, 1'b0, w);
        check("oor_busy", busy, 1);
        wait_idle();

        // Blank a digit.
        align(8);
        do_write(3'd3, 4'h9, 1'b1, 1'b0, w);
        wait_idle();

        // Write in the blink-wrap cycle: a single scan.
        align(D - 1);
        do_write(3'd5, 4'hA, 1'b0, 1'b0, w);
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("collision_busy_cycles", n, 6);
        check("collision_d5", hex_out[41:35], 7'h08);

        // Wrap during SCAN: one back-to-back rescan.
        align(D - 3);
        do_write(3'd1, 4'h9, 1'b0, 1'b0, w);
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("rescan_busy_cycles", n, 12);
        @(negedge clk);
        check("sb_drained", exp_q.size(), 0);
        check("accept_count", acc_cnt, wr_count);
        check("bp_d0", hex_out[6:0], 7'h79);

        // Blink on the single-digit instance, BLINK_DIV = 4.
        wr_valid_b = 1'b1; wr_digit_b = 3'd0; wr_value_b = 4'h0; wr_blank_b = 1'b0; wr_blink_b = 1'b1;
        n = 0;
        while (!wr_ready_b && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!wr_ready_b) timeout("blink_write");
        @(posedge clk);
        @(negedge clk);
        wr_valid_b = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            exp_b = (((cnt_bm == 0) ? ~ph_bm : ph_bm) == 1'b1) ? 7'h7F : 7'h40;
            check("blink_d0", hex_out_b, exp_b);
            @(negedge clk);
        end

        // Asynchronous reset in the middle of a scan.
        align(8);
        do_write(3'd4, 4'h2, 1'b0, 1'b0, w);
        check("midscan_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        check("async_reset_hex", hex_out, ALL_DARK);
        check("async_reset_busy", busy, 0);
        check("async_reset_ready", wr_ready, 1);
        exp_q.delete();
        img_m = ALL_DARK;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("after_reset_hex", hex_out, ALL_DARK);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

endmodule
